// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - shares one sequential Booth multiplier among NREQ requesters.
// Define BOOTH_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module booth_mul_arbiter #(
    parameter int WIDTH       = 4,
    parameter int NREQ        = 3,
    parameter int MUL_LATENCY = 10
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_mpd,
    input  logic [NREQ*WIDTH-1:0]     req_mpr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_res,
    output logic                      mul_enable,
    output logic [WIDTH-1:0]          mul_mpd,
    output logic [WIDTH-1:0]          mul_mpr,
    input  logic [2*WIDTH-1:0]        mul_res,
    output logic                      busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] gnt_q;
    logic [IDW-1:0] grant;
    logic [CW-1:0]  cnt;

`ifdef BOOTH_ARB_RR_EN
    logic [IDW-1:0] ptr;

    // Walk downwards so the requester closest to the pointer is written last and wins.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) grant = IDW'(idx);
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) grant = IDW'(k);
        end
    end
`endif

    // Gated by reset_n so no accept is ever shown while reset is asserted.
    assign req_ready = (reset_n && state == IDLE && |req_valid) ? (NREQ'(1) << grant) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt_q      <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_res    <= '0;
            mul_enable <= 1'b0;
            mul_mpd    <= '0;
            mul_mpr    <= '0;
            busy       <= 1'b0;
`ifdef BOOTH_ARB_RR_EN
            ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt_q      <= grant;
                        mul_mpd    <= req_mpd[int'(grant)*WIDTH +: WIDTH];
                        mul_mpr    <= req_mpr[int'(grant)*WIDTH +: WIDTH];
                        mul_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    mul_enable <= 1'b0;
                    cnt        <= CW'(MUL_LATENCY - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_res   <= mul_res;
                        rsp_id    <= gnt_q;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef BOOTH_ARB_RR_EN
                        ptr <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter with a behavioural multiplier.
module tb_booth_mul_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 3;
    localparam int ML    = 10;

    logic                    clock, reset_n;
    logic [NREQ-1:0]         req_valid, req_ready;
    logic [NREQ*WIDTH-1:0]   req_mpd, req_mpr;
    logic                    rsp_valid, rsp_ready;
    logic [1:0]              rsp_id;
    logic [2*WIDTH-1:0]      rsp_res, mul_res;
    logic                    mul_enable, busy;
    logic [WIDTH-1:0]        mul_mpd, mul_mpr;

    booth_mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_LATENCY(ML)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mpd(req_mpd), .req_mpr(req_mpr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res),
        .mul_enable(mul_enable), .mul_mpd(mul_mpd), .mul_mpr(mul_mpr),
        .mul_res(mul_res), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;
    logic [WIDTH-1:0] a [NREQ];
    logic [WIDTH-1:0] b [NREQ];

    function automatic logic [2*WIDTH-1:0] smul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic signed [2*WIDTH-1:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
    endfunction

    // Multiplier stand-in: shows a wrong value until exactly ML cycles after the load cycle.
    logic [2*WIDTH-1:0] prod;
    int mcnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcnt    <= 0;
            mul_res <= '0;
        end else if (mul_enable) begin
            prod    <= smul(mul_mpd, mul_mpr);
            mcnt    <= 1;
            mul_res <= (ML == 1) ? smul(mul_mpd, mul_mpr) : smul(mul_mpd, mul_mpr) ^ 8'hA5;
        end else if (mcnt > 0 && mcnt < ML) begin
            mcnt    <= mcnt + 1;
            mul_res <= (mcnt + 1 == ML) ? prod : prod ^ 8'h5A;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m);
`ifdef BOOTH_ARB_RR_EN
        for (int k = 0; k < NREQ; k++)
            if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (m[k]) return k;
`endif
        return 0;
    endfunction

    // Entered and left at the falling edge of an IDLE cycle.
    task automatic run_txn(input logic [NREQ-1:0] mask, input int hold, output int g, output time t_acc);
        int k, en_cnt;
        bit ok;
        logic [2*WIDTH-1:0] r;
        logic [1:0] id;
        rsp_ready = 1'b0;
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_mpd[i*WIDTH +: WIDTH] = a[i];
            req_mpr[i*WIDTH +: WIDTH] = b[i];
        end
        #1;
        g = pick(mask);
        check("idle_busy", busy, 0);
        check("grant", req_ready, 64'(1) << g);
        @(posedge clock);
        t_acc = $time;
        k = 0; en_cnt = 0; ok = 1;
        while (k <= 40) begin
            @(negedge clock);
            k++;
            if (mul_enable) begin
                en_cnt++;
                check("load_mpd", mul_mpd, a[g]);
                check("load_mpr", mul_mpr, b[g]);
            end
            if (req_ready != '0 || !busy) ok = 0;
            if (rsp_valid) break;
        end
        check("latency", k, ML + 2);
        check("mul_en_cnt", en_cnt, 1);
        check("busy_ready", ok, 1);
        check("rsp_res", rsp_res, smul(a[g], b[g]));
        check("rsp_id", rsp_id, g);
        r = rsp_res; id = rsp_id; ok = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_res !== r || rsp_id !== id || req_ready != '0 || !busy) ok = 0;
        end
        if (hold > 0) check("hold_stable", ok, 1);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("post_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
`ifdef BOOTH_ARB_RR_EN
        ptr = (g + 1) % NREQ;
`endif
    endtask

    initial begin
        int g, gap;
        time t0, t1;
        bit ok;
        int exp_order [4];
`ifdef BOOTH_ARB_RR_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        reset_n = 1'b0; rsp_ready = 1'b0; req_valid = '0; req_mpd = '0; req_mpr = '0;
        repeat (2) @(negedge clock);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_res", rsp_res, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_en", mul_enable, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // All requesters held valid, response taken immediately.
        for (int i = 0; i < NREQ; i++) begin a[i] = 4'(i + 1); b[i] = 4'(i + 5); end
        t0 = 0;
        for (int n = 0; n < 4; n++) begin
            run_txn(3'b111, 0, g, t1);
            check("held_order", g, exp_order[n]);
            if (n > 0) check("throughput", (t1 - t0) / 10, ML + 3);
            t0 = t1;
        end
        req_valid = '0;
        @(negedge clock);

        a[0] = 4'd3; b[0] = 4'hE;
        run_txn(3'b001, 0, g, t1);
        check("fa_res", rsp_res, 8'hFA);
        a[1] = 4'h8; b[1] = 4'h8;
        run_txn(3'b010, 5, g, t1);
        check("m8m8", rsp_res, 8'h40);
        a[1] = 4'h7; b[1] = 4'h8;
        run_txn(3'b010, 0, g, t1);
        check("p7m8", rsp_res, 8'hC8);
        req_valid = '0;
        @(negedge clock);

        // Abort during WAIT: nothing may come out afterwards.
        a[0] = 4'd5; b[0] = 4'd5;
        req_valid = 3'b001;
        req_mpd[3:0] = a[0]; req_mpr[3:0] = b[0];
        @(posedge clock);
        #1 req_valid = '0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        req_valid = 3'b111;
        #1;
        check("abort_busy", busy, 0);
        check("abort_mul_en", mul_enable, 0);
        check("abort_ops", {mul_mpd, mul_mpr}, 0);
        check("abort_rsp", {rsp_valid, rsp_id, rsp_res}, 0);
        check("abort_ready", req_ready, 0);
        @(negedge clock);
        req_valid = '0;
        reset_n = 1'b1;
        ptr = 0;
        ok = 1;
        repeat (20) begin
            @(negedge clock);
            if (rsp_valid || busy) ok = 0;
        end
        check("no_rsp_after_abort", ok, 1);
        a[0] = 4'd2; b[0] = 4'd3;
        run_txn(3'b001, 0, g, t1);
        check("after_abort_res", rsp_res, 8'h06);

        // Pointer wrap past the last requester.
        run_txn(3'b100, 0, g, t1);
        run_txn(3'b011, 0, g, t1);
        check("wrap_grant", g, 0);
        run_txn(3'b111, 0, g, t1);
`ifdef BOOTH_ARB_RR_EN
        check("wrap_next", g, 1);
`else
        check("wrap_next", g, 0);
`endif
        req_valid = '0;
        @(negedge clock);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                a[i] = 4'($urandom);
                b[i] = 4'($urandom);
            end
            run_txn(3'($urandom_range(1, 7)), $urandom_range(0, 3), g, t1);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                req_valid = '0;
                repeat (gap) @(negedge clock);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
